// File: rtl/fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : fifo_param
// Purpose  : Single-clock FIFO with a parameterised data width, depth and read
//            mode. Provides an occupancy count, almost-full and almost-empty
//            thresholds, and sticky overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_underflow,
    input  logic                  i_clr_err
);

    localparam logic [ADDR_WIDTH:0]   c_DEPTH    = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_AF_LEVEL = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   c_AE_LEVEL = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0]   c_CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_rd_acc;
    logic w_wr_acc;

    // Flags decode only the registered count, so wr/rd never reach them combinationally
    assign w_full   = (r_count == c_DEPTH);
    assign w_empty  = (r_count == '0);
    assign w_rd_acc = i_rd & ~w_empty;
    assign w_wr_acc = i_wr & (~w_full | w_rd_acc);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            if (w_wr_acc && !w_rd_acc)      r_count <= r_count + c_CNT_ONE;
            else if (w_rd_acc && !w_wr_acc) r_count <= r_count - c_CNT_ONE;
            // A new error event in the same cycle as a clear keeps the flag set
            if (i_wr && !w_wr_acc) r_overflow <= 1'b1;
            else if (i_clr_err)    r_overflow <= 1'b0;
            if (i_rd && w_empty)   r_underflow <= 1'b1;
            else if (i_clr_err)    r_underflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr] <= i_data_in;
    end

    generate
        if (FWFT) begin : g_fwft
            assign o_data_out = w_empty ? '0 : r_mem[r_rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_data_out;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)         r_data_out <= '0;
                else if (w_rd_acc) r_data_out <= r_mem[r_rd_ptr];
            end
            assign o_data_out = r_data_out;
        end
    endgenerate

    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_almost_full  = (r_count >= c_AF_LEVEL);
    assign o_almost_empty = (r_count <= c_AE_LEVEL);
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_param
// Purpose  : Drives standard and FWFT FIFO instances with identical stimulus
//            and compares both against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_param;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr, rd, clr;
    logic [DW-1:0] din;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [AW:0]   s_count, f_count;

    always #5 clk = ~clk;

    fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0)) u_std (
        .clk(clk), .rstn(rstn), .i_wr(wr), .i_data_in(din), .i_rd(rd),
        .o_data_out(s_dout), .o_full(s_full), .o_empty(s_empty),
        .o_almost_full(s_af), .o_almost_empty(s_ae), .o_count(s_count),
        .o_overflow(s_ovf), .o_underflow(s_unf), .i_clr_err(clr)
    );

    fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rstn(rstn), .i_wr(wr), .i_data_in(din), .i_rd(rd),
        .o_data_out(f_dout), .o_full(f_full), .o_empty(f_empty),
        .o_almost_full(f_af), .o_almost_empty(f_ae), .o_count(f_count),
        .o_overflow(f_ovf), .o_underflow(f_unf), .i_clr_err(clr)
    );

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] q [$];
    logic          exp_ovf, exp_unf;
    logic [DW-1:0] exp_dout;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("std_count", s_count, n);
        chk("std_empty", s_empty, n == 0);
        chk("std_full", s_full, n == DEPTH);
        chk("std_afull", s_af, n >= AF);
        chk("std_aempty", s_ae, n <= AE);
        chk("std_ovf", s_ovf, exp_ovf);
        chk("std_unf", s_unf, exp_unf);
        chk("std_dout", s_dout, exp_dout);
        chk("fwft_count", f_count, n);
        chk("fwft_empty", f_empty, n == 0);
        chk("fwft_full", f_full, n == DEPTH);
        chk("fwft_afull", f_af, n >= AF);
        chk("fwft_aempty", f_ae, n <= AE);
        chk("fwft_ovf", f_ovf, exp_ovf);
        chk("fwft_unf", f_unf, exp_unf);
        if (n > 0) chk("fwft_dout", f_dout, q[0]);
    endtask

    task automatic model_reset();
        q.delete();
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
        exp_dout = '0;
    endtask

    // One clock of stimulus; the model applies the accept rules to the queue
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        bit rd_ok, wr_ok;
        wr = w; din = d; rd = r; clr = c;
        @(posedge clk);
        rd_ok = r && (q.size() > 0);
        wr_ok = w && ((q.size() < DEPTH) || rd_ok);
        if (w && !wr_ok)              exp_ovf = 1'b1;
        else if (c)                   exp_ovf = 1'b0;
        if (r && q.size() == 0)       exp_unf = 1'b1;
        else if (c)                   exp_unf = 1'b0;
        if (rd_ok) exp_dout = q.pop_front();
        if (wr_ok) q.push_back(d);
        #1;
        wr = 1'b0; rd = 1'b0; clr = 1'b0;
        check_all();
    endtask

    task automatic async_reset();
        #2 rstn = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; wr = 1'b0; rd = 1'b0; clr = 1'b0; din = '0;
        model_reset();
        #3 check_all();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        step(0, '0, 0, 0);

        for (int i = 1; i <= 8; i++) step(1, DW'(i * 32'h11), 0, 0);
        step(1, 32'h99, 0, 0);
        step(0, '0, 0, 1);
        step(1, 32'hAA, 1, 0);
        for (int i = 0; i < 9; i++) step(0, '0, 1, 0);

        step(1, 32'h5, 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 1);
        step(0, '0, 0, 1);
        step(0, '0, 1, 0);

        step(1, 32'h3C, 0, 0);
        step(0, '0, 0, 0);
        step(0, '0, 1, 0);

        for (int i = 0; i < 4; i++) step(1, 32'hB0 + DW'(i), 0, 0);
        for (int i = 0; i < 20; i++) step(i % 4 != 2, 32'hC000 + DW'(i), i % 4 != 0, 0);

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15) == 0);

        for (int i = 0; i <= DEPTH && q.size() > 0; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 32'hD0 + DW'(i), 0, 0);
        async_reset();
        step(0, '0, 0, 0);
        step(1, 32'hBEEF, 0, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
